// File: rtl/tdc_meas_sequencer.sv
// tdc_meas_sequencer: AXI4-Lite master that runs one TDC measurement per start edge.
// Each measurement writes CFG, sets CTRL.start, polls STATUS.done, reads RESULT,
// then clears CTRL.start. A timeout or a bad response skips ahead to the CTRL clear.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for a 0->1 edge on INIT_AXI_TXN
//   S_WR_CFG | writing the latched config word to CFG (+4)
//   S_WR_GO  | writing 1 to CTRL (+0) to start the TDC
//   S_POLL   | reading STATUS (+8) until done or the poll limit is reached
//   S_RD_RES | reading RESULT (+C)
//   S_WR_CLR | writing 0 to CTRL (+0); always runs, even after an error
//   S_DONE   | one-cycle TXN_DONE pulse, then back to S_IDLE
module tdc_meas_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TDC_BASE_ADDR = 'h4000_0000,
    parameter int C_POLL_TIMEOUT = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_AXI_TXN,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   CFG_DATA,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RESULT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_CFG, S_WR_GO, S_POLL, S_RD_RES, S_WR_CLR, S_DONE
    } state_t;

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] ADDR_CTRL   = C_TDC_BASE_ADDR;
    localparam logic [AW-1:0] ADDR_CFG    = C_TDC_BASE_ADDR + AW'(4);
    localparam logic [AW-1:0] ADDR_STATUS = C_TDC_BASE_ADDR + AW'(8);
    localparam logic [AW-1:0] ADDR_RESULT = C_TDC_BASE_ADDR + AW'(12);
    localparam logic [15:0]   POLL_LIMIT  = 16'(C_POLL_TIMEOUT);

    state_t          state_q, state_d;
    logic            init_q, init_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   result_q, result_d;
    logic [15:0]     poll_cnt_q, poll_cnt_d;
    logic            error_q, error_d;
    logic            txn_done_q, txn_done_d;

    logic            start_edge;
    logic            b_hs, r_hs;
    logic            issue_wr, issue_rd;
    logic [AW-1:0]   op_addr;
    logic [DW-1:0]   op_data;
    logic [15:0]     poll_next;

    // Next-state, handshake retirement and launch of the next bus operation.
    always_comb begin
        state_d    = state_q;
        init_d     = INIT_AXI_TXN;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        poll_cnt_d = poll_cnt_q;
        error_d    = error_q;
        txn_done_d = 1'b0;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        op_addr    = '0;
        op_data    = '0;

        start_edge = INIT_AXI_TXN & ~init_q;
        b_hs       = M_AXI_BVALID & bready_q;
        r_hs       = M_AXI_RVALID & rready_q;
        poll_next  = poll_cnt_q + 16'd1;

        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (arvalid_q && M_AXI_ARREADY) arvalid_d = 1'b0;
        if (b_hs)                       bready_d  = 1'b0;
        if (r_hs)                       rready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    error_d  = 1'b0;
                    state_d  = S_WR_CFG;
                    issue_wr = 1'b1;
                    op_addr  = ADDR_CFG;
                    op_data  = CFG_DATA;
                end
            end
            S_WR_CFG, S_WR_GO: begin
                if (b_hs) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        error_d  = 1'b1;
                        state_d  = S_WR_CLR;
                        issue_wr = 1'b1;
                        op_addr  = ADDR_CTRL;
                    end else if (state_q == S_WR_CFG) begin
                        state_d  = S_WR_GO;
                        issue_wr = 1'b1;
                        op_addr  = ADDR_CTRL;
                        op_data  = DW'(1);
                    end else begin
                        state_d    = S_POLL;
                        poll_cnt_d = 16'd0;
                        issue_rd   = 1'b1;
                        op_addr    = ADDR_STATUS;
                    end
                end
            end
            S_POLL: begin
                if (r_hs) begin
                    if (M_AXI_RRESP != 2'b00 || (!M_AXI_RDATA[0] && poll_next >= POLL_LIMIT)) begin
                        error_d  = 1'b1;
                        state_d  = S_WR_CLR;
                        issue_wr = 1'b1;
                        op_addr  = ADDR_CTRL;
                    end else if (M_AXI_RDATA[0]) begin
                        state_d  = S_RD_RES;
                        issue_rd = 1'b1;
                        op_addr  = ADDR_RESULT;
                    end else begin
                        poll_cnt_d = poll_next;
                        issue_rd   = 1'b1;
                        op_addr    = ADDR_STATUS;
                    end
                end
            end
            S_RD_RES: begin
                if (r_hs) begin
                    if (M_AXI_RRESP == 2'b00) result_d = M_AXI_RDATA;
                    else                      error_d  = 1'b1;
                    state_d  = S_WR_CLR;
                    issue_wr = 1'b1;
                    op_addr  = ADDR_CTRL;
                end
            end
            S_WR_CLR: begin
                if (b_hs) begin
                    if (M_AXI_BRESP != 2'b00) error_d = 1'b1;
                    state_d    = S_DONE;
                    txn_done_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            awaddr_d  = op_addr;
            wdata_d   = op_data;
        end
        if (issue_rd) begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = op_addr;
        end
    end

    // State and registered outputs; reset drops in-flight VALIDs at once.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            init_q     <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            poll_cnt_q <= 16'd0;
            error_q    <= 1'b0;
            txn_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            poll_cnt_q <= poll_cnt_d;
            error_q    <= error_d;
            txn_done_q <= txn_done_d;
        end
    end

    assign TXN_DONE      = txn_done_q;
    assign ERROR         = error_q;
    assign RESULT        = result_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Bench for tdc_meas_sequencer: a behavioural TDC register slave with optional
// ready stalls and injected SLVERR, driven by directed measurement runs.
module tb_tdc_meas_sequencer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        ACLK, ARESETN, INIT_AXI_TXN;
    logic [31:0] CFG_DATA;
    logic        TXN_DONE, ERROR;
    logic [31:0] RESULT;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    tdc_meas_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_TDC_BASE_ADDR(BASE),
        .C_POLL_TIMEOUT(8)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .INIT_AXI_TXN(INIT_AXI_TXN), .CFG_DATA(CFG_DATA),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR), .RESULT(RESULT),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // slave configuration and observation
    bit          stall_en = 1'b0;
    int          done_at = 1;
    int          err_wr_idx = -1;
    logic [31:0] result_val = 32'h0;
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          wr_idx = 0, n_status = 0, n_result = 0, n_done = 0, viol = 0;
    logic        err_at_done = 1'b0;

    logic        aw_got, w_got, ar_got, aw_pend, w_pend, ar_pend, b_pend, r_pend;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    int          aw_wait, w_wait, ar_wait;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    function automatic int stall();
        return stall_en ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // Slave model: decides READY/response at the falling edge; handshakes land on the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
            M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
            M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = 32'h0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
            p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        end else begin
            if (p_awv && !p_awr && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr)) viol++;
            if (p_wv && !p_wr && (!M_AXI_WVALID || M_AXI_WDATA !== p_wdata)) viol++;
            if (p_arv && !p_arr && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr)) viol++;

            if (aw_pend) begin aw_got = 1; aw_pend = 0; end
            if (w_pend)  begin w_got = 1;  w_pend = 0;  end
            if (ar_pend) begin ar_got = 1; ar_pend = 0; end
            if (b_pend)  begin M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00; b_pend = 0; end
            if (r_pend)  begin M_AXI_RVALID = 0; r_pend = 0; end

            M_AXI_AWREADY = 1'b0;
            if (M_AXI_AWVALID && !aw_got) begin
                if (aw_wait > 0) aw_wait--;
                else begin
                    M_AXI_AWREADY = 1'b1; cap_awaddr = M_AXI_AWADDR; aw_pend = 1; aw_wait = stall();
                end
            end
            M_AXI_WREADY = 1'b0;
            if (M_AXI_WVALID && !w_got) begin
                if (w_wait > 0) w_wait--;
                else begin
                    M_AXI_WREADY = 1'b1; cap_wdata = M_AXI_WDATA; w_pend = 1; w_wait = stall();
                end
            end
            if (aw_got && w_got && !M_AXI_BVALID) begin
                wr_addr_log.push_back(cap_awaddr);
                wr_data_log.push_back(cap_wdata);
                M_AXI_BRESP = (wr_idx == err_wr_idx) ? 2'b10 : 2'b00;
                wr_idx++;
                M_AXI_BVALID = 1'b1;
                aw_got = 0; w_got = 0;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1;

            M_AXI_ARREADY = 1'b0;
            if (M_AXI_ARVALID && !ar_got) begin
                if (ar_wait > 0) ar_wait--;
                else begin
                    M_AXI_ARREADY = 1'b1; cap_araddr = M_AXI_ARADDR; ar_pend = 1; ar_wait = stall();
                end
            end
            if (ar_got && !M_AXI_RVALID) begin
                ar_got = 0;
                M_AXI_RVALID = 1'b1;
                M_AXI_RRESP = 2'b00;
                if (cap_araddr == BASE + 32'h8) begin
                    n_status++;
                    M_AXI_RDATA = (done_at != 0 && n_status >= done_at) ? 32'h1 : 32'h0;
                end else if (cap_araddr == BASE + 32'hC) begin
                    n_result++;
                    M_AXI_RDATA = result_val;
                end else begin
                    M_AXI_RDATA = 32'hDEAD_DEAD;
                end
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_pend = 1;

            p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
            p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;  p_wdata  = M_AXI_WDATA;
            p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
        end
    end

    // Count TXN_DONE pulses and capture ERROR alongside each.
    always @(negedge ACLK) begin
        if (ARESETN && TXN_DONE) begin
            n_done++;
            err_at_done = ERROR;
        end
    end

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_idx = 0; n_status = 0; n_result = 0; n_done = 0; viol = 0;
    endtask

    task automatic pulse_start(input logic [31:0] cfg);
        @(negedge ACLK);
        CFG_DATA = cfg;
        INIT_AXI_TXN = 1'b1;
        @(negedge ACLK);
        INIT_AXI_TXN = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (n_done == 0 && cycles < budget) begin
            @(negedge ACLK);
            cycles++;
        end
        check_eq("done_seen", 32'(n_done != 0), 32'd1);
        repeat (6) @(negedge ACLK);
    endtask

    // n_wr is 3 for a full run (CFG, CTRL=1, CTRL=0) or 2 when the CFG write errors.
    task automatic check_writes(input string tag, input int n_wr, input logic [31:0] cfg);
        check_eq({tag, "_nwr"}, 32'(wr_addr_log.size()), 32'(n_wr));
        if (wr_addr_log.size() == n_wr) begin
            check_eq({tag, "_w0a"}, wr_addr_log[0], BASE + 32'h4);
            check_eq({tag, "_w0d"}, wr_data_log[0], cfg);
            if (n_wr == 3) begin
                check_eq({tag, "_w1a"}, wr_addr_log[1], BASE);
                check_eq({tag, "_w1d"}, wr_data_log[1], 32'h1);
            end
            check_eq({tag, "_wla"}, wr_addr_log[n_wr-1], BASE);
            check_eq({tag, "_wld"}, wr_data_log[n_wr-1], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int k;
        ARESETN = 1'b0;
        INIT_AXI_TXN = 1'b0;
        CFG_DATA = 32'h0;
        repeat (3) @(negedge ACLK);
        check_eq("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
        check_eq("rst_wvalid", 32'(M_AXI_WVALID), 32'd0);
        check_eq("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        check_eq("rst_ready", 32'({M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
        check_eq("rst_flags", 32'({TXN_DONE, ERROR}), 32'd0);
        check_eq("rst_result", RESULT, 32'h0);
        check_eq("rst_awaddr", M_AXI_AWADDR, 32'h0);
        check_eq("rst_wdata", M_AXI_WDATA, 32'h0);
        check_eq("const_strb_prot", 32'({M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}), 32'h3C0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // 1: zero-wait, done on first poll
        clear_log(); stall_en = 0; done_at = 1; result_val = 32'h0000_1234;
        pulse_start(32'h0101_FFFF);
        wait_done(200, cyc);
        check_eq("t1_latency_le16", 32'(cyc + 1 <= 16), 32'd1);
        check_writes("t1", 3, 32'h0101_FFFF);
        check_eq("t1_result", RESULT, 32'h0000_1234);
        check_eq("t1_status_rd", 32'(n_status), 32'd1);
        check_eq("t1_result_rd", 32'(n_result), 32'd1);
        check_eq("t1_ndone", 32'(n_done), 32'd1);
        check_eq("t1_err", 32'(err_at_done), 32'd0);

        // 2: done on 5th poll, random ready stalls
        clear_log(); stall_en = 1; done_at = 5; result_val = 32'hCAFE_F00D;
        pulse_start(32'hA5A5_0003);
        wait_done(400, cyc);
        check_writes("t2", 3, 32'hA5A5_0003);
        check_eq("t2_status_rd", 32'(n_status), 32'd5);
        check_eq("t2_result", RESULT, 32'hCAFE_F00D);
        check_eq("t2_no_early_drop", 32'(viol), 32'd0);
        check_eq("t2_ndone", 32'(n_done), 32'd1);
        check_eq("t2_err", 32'(err_at_done), 32'd0);

        // 3: STATUS never done -> timeout after 8 reads
        clear_log(); stall_en = 0; done_at = 0; result_val = 32'h1111_2222;
        pulse_start(32'h0000_0077);
        wait_done(400, cyc);
        check_writes("t3", 3, 32'h0000_0077);
        check_eq("t3_status_rd", 32'(n_status), 32'd8);
        check_eq("t3_result_rd", 32'(n_result), 32'd0);
        check_eq("t3_err_at_done", 32'(err_at_done), 32'd1);
        check_eq("t3_result_kept", RESULT, 32'hCAFE_F00D);

        // 4: SLVERR on the CFG write
        clear_log(); done_at = 1; err_wr_idx = 0; result_val = 32'h3333_4444;
        pulse_start(32'h0000_0042);
        wait_done(200, cyc);
        err_wr_idx = -1;
        check_writes("t4", 2, 32'h0000_0042);
        check_eq("t4_status_rd", 32'(n_status), 32'd0);
        check_eq("t4_err_at_done", 32'(err_at_done), 32'd1);
        check_eq("t4_err_sticky", 32'(ERROR), 32'd1);
        check_eq("t4_result_kept", RESULT, 32'hCAFE_F00D);
        check_eq("t4_ndone", 32'(n_done), 32'd1);

        // 5: new start clears ERROR; toggles while busy are ignored
        clear_log(); done_at = 1; result_val = 32'h5555_AAAA;
        pulse_start(32'h0000_00C5);
        check_eq("t5_err_cleared", 32'(ERROR), 32'd0);
        repeat (2) @(negedge ACLK);
        INIT_AXI_TXN = 1'b1; @(negedge ACLK);
        INIT_AXI_TXN = 1'b0; @(negedge ACLK);
        INIT_AXI_TXN = 1'b1; @(negedge ACLK);
        INIT_AXI_TXN = 1'b0;
        wait_done(200, cyc);
        repeat (20) @(negedge ACLK);
        check_eq("t5_ndone", 32'(n_done), 32'd1);
        check_writes("t5", 3, 32'h0000_00C5);
        check_eq("t5_result", RESULT, 32'h5555_AAAA);
        check_eq("t5_err", 32'(err_at_done), 32'd0);

        // 6: reset during POLL with ARVALID high
        clear_log(); stall_en = 1; done_at = 0;
        pulse_start(32'h0000_0099);
        k = 0;
        while (!(M_AXI_ARVALID && M_AXI_ARADDR == BASE + 32'h8) && k < 100) begin
            @(negedge ACLK);
            k++;
        end
        check_eq("t6_poll_reached", 32'(M_AXI_ARVALID), 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        check_eq("t6_rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        check_eq("t6_rst_araddr", M_AXI_ARADDR, 32'h0);
        check_eq("t6_rst_ready", 32'({M_AXI_BREADY, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID}), 32'd0);
        check_eq("t6_rst_result", RESULT, 32'h0);
        check_eq("t6_rst_flags", 32'({TXN_DONE, ERROR}), 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        clear_log(); stall_en = 0; done_at = 1; result_val = 32'h0BAD_BEEF;
        pulse_start(32'h0000_0123);
        wait_done(200, cyc);
        check_writes("t6", 3, 32'h0000_0123);
        check_eq("t6_result", RESULT, 32'h0BAD_BEEF);
        check_eq("t6_ndone", 32'(n_done), 32'd1);
        check_eq("t6_err", 32'(err_at_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
